// File: rtl/red_pitaya_asg_desc_queue.sv
// Descriptor queue feeding the multi-buffer ASG channel: software stages one descriptor,
// commits it into a 4-slot circular queue, and each buffer-done pulse retires the active slot.
module red_pitaya_asg_desc_queue #(
   parameter int unsigned RSZ   = 14,
   parameter int unsigned N_BUF = 4
) (
   input  logic                       dac_clk_i,
   input  logic                       dac_rst_i,
   input  logic                       sys_we_i,
   input  logic [3:0]                 sys_addr_i,
   input  logic [31:0]                sys_wdata_i,
   output logic [31:0]                sys_rdata_o,
   input  logic                       buf_done_i,
   output logic [14*N_BUF-1:0]        set_amp_all_o,
   output logic [14*N_BUF-1:0]        set_dc_all_o,
   output logic [(RSZ+16)*N_BUF-1:0]  set_start_all_o,
   output logic [(RSZ+16)*N_BUF-1:0]  set_end_all_o,
   output logic [(RSZ+16)*N_BUF-1:0]  set_step_all_o,
   output logic [16*N_BUF-1:0]        set_ncyc_all_o,
   output logic [16*N_BUF-1:0]        set_rnum_all_o,
   output logic [32*N_BUF-1:0]        set_rdly_all_o,
   output logic                       asg_rst_o,
   output logic                       q_ready_o,
   output logic [2:0]                 q_level_o
);

   localparam int unsigned PW = RSZ + 16;

   logic [13:0]   amp_q, amp_d, dc_q, dc_d;
   logic [PW-1:0] start_q, start_d, end_q, end_d, step_q, step_d;
   logic [15:0]   ncyc_q, ncyc_d, rnum_q, rnum_d;
   logic [31:0]   rdly_q, rdly_d;

   logic [14*N_BUF-1:0] amp_all_q, amp_all_d, dc_all_q, dc_all_d;
   logic [PW*N_BUF-1:0] start_all_q, start_all_d, end_all_q, end_all_d;
   logic [PW*N_BUF-1:0] step_all_q, step_all_d;
   logic [16*N_BUF-1:0] ncyc_all_q, ncyc_all_d, rnum_all_q, rnum_all_d;
   logic [32*N_BUF-1:0] rdly_all_q, rdly_all_d;

   logic [N_BUF-1:0] valid_q, valid_d;
   logic [1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
   logic [2:0]       level_q, level_d;
   logic             ovf_q, ovf_d, unf_q, unf_d, asg_rst_q, asg_rst_d;
   logic [31:0]      rdata_q, rdata_d;

   logic commit, flush, clr, retire, commit_ok, retire_ok, stop;

   always_comb begin
      commit    = sys_we_i && (sys_addr_i == 4'd8);
      flush     = sys_we_i && (sys_addr_i == 4'd9) && sys_wdata_i[0];
      clr       = sys_we_i && (sys_addr_i == 4'd9) && sys_wdata_i[1];
      // A flush discards any same-cycle commit or retire.
      retire    = buf_done_i && !flush;
      retire_ok = retire && (level_q != 3'd0);
      commit_ok = commit && !flush && ((level_q != 3'(N_BUF)) || retire_ok);
      rd_next   = rd_ptr_q + 2'd1;
      // Playback stops when the retire leaves the next slot empty and no commit refills it.
      stop      = retire_ok && !valid_q[rd_next] && !(commit_ok && (wr_ptr_q == rd_next));
   end

   always_comb begin
      amp_d   = amp_q;
      dc_d    = dc_q;
      start_d = start_q;
      end_d   = end_q;
      step_d  = step_q;
      ncyc_d  = ncyc_q;
      rnum_d  = rnum_q;
      rdly_d  = rdly_q;
      if (sys_we_i) begin
         case (sys_addr_i)
            4'd0:    amp_d   = sys_wdata_i[13:0];
            4'd1:    dc_d    = sys_wdata_i[13:0];
            4'd2:    start_d = sys_wdata_i[PW-1:0];
            4'd3:    end_d   = sys_wdata_i[PW-1:0];
            4'd4:    step_d  = sys_wdata_i[PW-1:0];
            4'd5:    ncyc_d  = sys_wdata_i[15:0];
            4'd6:    rnum_d  = sys_wdata_i[15:0];
            4'd7:    rdly_d  = sys_wdata_i;
            default: ;
         endcase
      end
   end

   always_comb begin
      amp_all_d   = amp_all_q;
      dc_all_d    = dc_all_q;
      start_all_d = start_all_q;
      end_all_d   = end_all_q;
      step_all_d  = step_all_q;
      ncyc_all_d  = ncyc_all_q;
      rnum_all_d  = rnum_all_q;
      rdly_all_d  = rdly_all_q;
      if (commit_ok) begin
         amp_all_d[32'(wr_ptr_q)*14 +: 14]   = amp_q;
         dc_all_d[32'(wr_ptr_q)*14 +: 14]    = dc_q;
         start_all_d[32'(wr_ptr_q)*PW +: PW] = start_q;
         end_all_d[32'(wr_ptr_q)*PW +: PW]   = end_q;
         step_all_d[32'(wr_ptr_q)*PW +: PW]  = step_q;
         ncyc_all_d[32'(wr_ptr_q)*16 +: 16]  = ncyc_q;
         rnum_all_d[32'(wr_ptr_q)*16 +: 16]  = rnum_q;
         rdly_all_d[32'(wr_ptr_q)*32 +: 32]  = rdly_q;
      end
   end

   always_comb begin
      valid_d  = valid_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         valid_d  = '0;
         wr_ptr_d = 2'd0;
         rd_ptr_d = 2'd0;
         level_d  = 3'd0;
      end else begin
         if (retire_ok) valid_d[rd_ptr_q] = 1'b0;
         // When full, wr_ptr == rd_ptr, so the write must win.
         if (commit_ok) valid_d[wr_ptr_q] = 1'b1;
         wr_ptr_d = wr_ptr_q + 2'(commit_ok);
         rd_ptr_d = rd_ptr_q + 2'(retire_ok);
         level_d  = level_q + 3'(commit_ok) - 3'(retire_ok);
      end
      ovf_d     = (ovf_q && !clr) || (commit && !flush && !commit_ok);
      unf_d     = (unf_q && !clr) || (retire && !retire_ok) || stop;
      asg_rst_d = flush || stop;
   end

   always_comb begin
      case (sys_addr_i)
         4'd0:    rdata_d = 32'(amp_q);
         4'd1:    rdata_d = 32'(dc_q);
         4'd2:    rdata_d = 32'(start_q);
         4'd3:    rdata_d = 32'(end_q);
         4'd4:    rdata_d = 32'(step_q);
         4'd5:    rdata_d = 32'(ncyc_q);
         4'd6:    rdata_d = 32'(rnum_q);
         4'd7:    rdata_d = rdly_q;
         4'd9:    rdata_d = {23'd0, unf_q, ovf_q, rd_ptr_q, wr_ptr_q, level_q};
         default: rdata_d = 32'd0;
      endcase
   end

   always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
      if (dac_rst_i) begin
         amp_q       <= '0;
         dc_q        <= '0;
         start_q     <= '0;
         end_q       <= '0;
         step_q      <= '0;
         ncyc_q      <= '0;
         rnum_q      <= '0;
         rdly_q      <= '0;
         amp_all_q   <= '0;
         dc_all_q    <= '0;
         start_all_q <= '0;
         end_all_q   <= '0;
         step_all_q  <= '0;
         ncyc_all_q  <= '0;
         rnum_all_q  <= '0;
         rdly_all_q  <= '0;
         valid_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         asg_rst_q   <= 1'b0;
         rdata_q     <= '0;
      end else begin
         amp_q       <= amp_d;
         dc_q        <= dc_d;
         start_q     <= start_d;
         end_q       <= end_d;
         step_q      <= step_d;
         ncyc_q      <= ncyc_d;
         rnum_q      <= rnum_d;
         rdly_q      <= rdly_d;
         amp_all_q   <= amp_all_d;
         dc_all_q    <= dc_all_d;
         start_all_q <= start_all_d;
         end_all_q   <= end_all_d;
         step_all_q  <= step_all_d;
         ncyc_all_q  <= ncyc_all_d;
         rnum_all_q  <= rnum_all_d;
         rdly_all_q  <= rdly_all_d;
         valid_q     <= valid_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         asg_rst_q   <= asg_rst_d;
         rdata_q     <= rdata_d;
      end
   end

   assign set_amp_all_o   = amp_all_q;
   assign set_dc_all_o    = dc_all_q;
   assign set_start_all_o = start_all_q;
   assign set_end_all_o   = end_all_q;
   assign set_step_all_o  = step_all_q;
   assign set_ncyc_all_o  = ncyc_all_q;
   assign set_rnum_all_o  = rnum_all_q;
   assign set_rdly_all_o  = rdly_all_q;
   assign asg_rst_o       = asg_rst_q;
   assign q_ready_o       = (level_q != 3'd0);
   assign q_level_o       = level_q;
   assign sys_rdata_o     = rdata_q;

endmodule

// File: tb/tb_red_pitaya_asg_desc_queue.sv
// Self-checking bench for red_pitaya_asg_desc_queue: register table, queue corner cases,
// scoreboard of committed amplitudes per slot.
module tb_red_pitaya_asg_desc_queue;

   localparam int unsigned RSZ   = 14;
   localparam int unsigned N_BUF = 4;
   localparam int unsigned PW    = RSZ + 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 we;
   logic [3:0]           addr;
   logic [31:0]          wdata;
   logic [31:0]          rdata;
   logic                 done;
   logic [14*N_BUF-1:0]  amp_all, dc_all;
   logic [PW*N_BUF-1:0]  start_all, end_all, step_all;
   logic [16*N_BUF-1:0]  ncyc_all, rnum_all;
   logic [32*N_BUF-1:0]  rdly_all;
   logic                 asg_rst, ready;
   logic [2:0]           level;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic        do_wr;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      int          slot;
      logic [13:0] amp;
   } sb_t;

   vec_t vecs[12];
   sb_t  sb_q[$];

   red_pitaya_asg_desc_queue #(.RSZ(RSZ), .N_BUF(N_BUF)) dut (
      .dac_clk_i       (clk),
      .dac_rst_i       (rst),
      .sys_we_i        (we),
      .sys_addr_i      (addr),
      .sys_wdata_i     (wdata),
      .sys_rdata_o     (rdata),
      .buf_done_i      (done),
      .set_amp_all_o   (amp_all),
      .set_dc_all_o    (dc_all),
      .set_start_all_o (start_all),
      .set_end_all_o   (end_all),
      .set_step_all_o  (step_all),
      .set_ncyc_all_o  (ncyc_all),
      .set_rnum_all_o  (rnum_all),
      .set_rdly_all_o  (rdly_all),
      .asg_rst_o       (asg_rst),
      .q_ready_o       (ready),
      .q_level_o       (level)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      we    = 1'b1;
      addr  = a;
      wdata = d;
      tick();
      we    = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
      addr = a;
      tick();
      chk(name, 64'(rdata), 64'(exp));
   endtask

   // Commit with the given amplitude; queue the expected slot contents when accepted.
   task automatic commit_amp(input logic [13:0] a, input int slot, input bit accept);
      wr(4'd0, 32'(a));
      wr(4'd8, 32'd0);
      if (accept) sb_q.push_back('{slot: slot, amp: a});
   endtask

   task automatic check_sb(input string name);
      sb_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk($sformatf("%s_slot%0d_amp", name, e.slot), 64'(amp_all[e.slot*14 +: 14]),
             64'(e.amp));
      end
   endtask

   initial begin
      rst   = 1'b1;
      we    = 1'b0;
      addr  = 4'd0;
      wdata = 32'd0;
      done  = 1'b0;

      vecs[0]  = '{1'b1, 4'd0,  32'hFFFF_FFFF, 32'h0000_3FFF};
      vecs[1]  = '{1'b1, 4'd1,  32'h1234_5678, 32'h0000_1678};
      vecs[2]  = '{1'b1, 4'd2,  32'hFFFF_FFFF, 32'h3FFF_FFFF};
      vecs[3]  = '{1'b1, 4'd3,  32'hC000_0001, 32'h0000_0001};
      vecs[4]  = '{1'b1, 4'd4,  32'hABCD_1234, 32'h2BCD_1234};
      vecs[5]  = '{1'b1, 4'd5,  32'h0001_BEEF, 32'h0000_BEEF};
      vecs[6]  = '{1'b1, 4'd6,  32'hFFFF_0042, 32'h0000_0042};
      vecs[7]  = '{1'b1, 4'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vecs[8]  = '{1'b0, 4'd8,  32'h0,         32'h0};
      vecs[9]  = '{1'b0, 4'd9,  32'h0,         32'h0};
      vecs[10] = '{1'b1, 4'd10, 32'h0000_0055, 32'h0};
      vecs[11] = '{1'b1, 4'd15, 32'hFFFF_FFFF, 32'h0};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_asg_rst", 64'(asg_rst), 64'd0);
      chk("rst_rdata", 64'(rdata), 64'd0);
      chk("rst_amp_all", 64'(amp_all), 64'd0);
      chk("rst_rdly_all", rdly_all[63:0], 64'd0);
      rst = 1'b0;

      // Register write/readback table
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
         rd(vecs[i].addr, vecs[i].exp, $sformatf("reg%0d", vecs[i].addr));
      end
      chk("table_level", 64'(level), 64'd0);

      // First commit lands in slot 0
      wr(4'd0, 32'h1000);
      wr(4'd3, 32'h3FFF_0000);
      wr(4'd8, 32'd0);
      chk("c1_amp0", 64'(amp_all[13:0]), 64'h1000);
      chk("c1_end0", 64'(end_all[PW-1:0]), 64'h3FFF_0000);
      chk("c1_level", 64'(level), 64'd1);
      chk("c1_ready", 64'(ready), 64'd1);
      rd(4'd9, 32'h009, "c1_status");

      // Overflow: five commits into an empty queue
      wr(4'd9, 32'd3);
      chk("fl0_asg_rst", 64'(asg_rst), 64'd1);
      chk("fl0_level", 64'(level), 64'd0);
      for (int i = 0; i < 5; i++) commit_amp(14'(32'h200 + i), i, i < 4);
      chk("ovf_level", 64'(level), 64'd4);
      check_sb("ovf");
      rd(4'd9, 32'h084, "ovf_status");

      // Full queue: retire and commit in the same cycle
      wr(4'd0, 32'h3AA);
      we   = 1'b1;
      addr = 4'd8;
      done = 1'b1;
      tick();
      we   = 1'b0;
      done = 1'b0;
      chk("full_rc_level", 64'(level), 64'd4);
      chk("full_rc_amp0", 64'(amp_all[13:0]), 64'h3AA);
      chk("full_rc_amp1", 64'(amp_all[27:14]), 64'h201);
      chk("full_rc_asg_rst", 64'(asg_rst), 64'd0);
      rd(4'd9, 32'h0AC, "full_rc_status");

      // Underrun: retire the only valid slot
      wr(4'd9, 32'd3);
      tick();
      chk("fl1_asg_rst_low", 64'(asg_rst), 64'd0);
      commit_amp(14'h77, 0, 1'b1);
      check_sb("unf");
      chk("unf_level1", 64'(level), 64'd1);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("unf_level0", 64'(level), 64'd0);
      chk("unf_asg_rst_hi", 64'(asg_rst), 64'd1);
      tick();
      chk("unf_asg_rst_lo", 64'(asg_rst), 64'd0);
      rd(4'd9, 32'h128, "unf_status");
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("unf2_level", 64'(level), 64'd0);
      chk("unf2_asg_rst", 64'(asg_rst), 64'd0);

      // Flush with three slots filled (slots 1..3), after one normal retire
      for (int i = 0; i < 3; i++) commit_amp(14'(32'h301 + i), i + 1, 1'b1);
      check_sb("fill3");
      chk("fill3_level", 64'(level), 64'd3);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("ret3_level", 64'(level), 64'd2);
      chk("ret3_asg_rst", 64'(asg_rst), 64'd0);
      wr(4'd9, 32'd1);
      chk("fl2_level", 64'(level), 64'd0);
      chk("fl2_ready", 64'(ready), 64'd0);
      chk("fl2_asg_rst_hi", 64'(asg_rst), 64'd1);
      tick();
      chk("fl2_asg_rst_lo", 64'(asg_rst), 64'd0);
      chk("fl2_slot2_kept", 64'(amp_all[41:28]), 64'h302);
      rd(4'd9, 32'h100, "fl2_status");
      wr(4'd9, 32'd2);
      rd(4'd9, 32'h000, "clr_status");

      // Asynchronous reset between clock edges
      commit_amp(14'h0A5, 0, 1'b1);
      commit_amp(14'h05A, 1, 1'b1);
      check_sb("pre_rst");
      we    = 1'b1;
      addr  = 4'd9;
      wdata = 32'd1;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_level", 64'(level), 64'd0);
      chk("arst_ready", 64'(ready), 64'd0);
      chk("arst_amp_all", 64'(amp_all), 64'd0);
      chk("arst_start_all", start_all[63:0], 64'd0);
      chk("arst_asg_rst", 64'(asg_rst), 64'd0);
      we = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("post_rst_asg_rst%0d", i), 64'(asg_rst), 64'd0);
      end
      rd(4'd9, 32'h000, "post_rst_status");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/red_pitaya_asg_desc_queue.md
Name: red_pitaya_asg_desc_queue

Overview:
- Descriptor queue directly upstream of the multi-buffer ASG channel.
- Software stages one waveform descriptor through the register bus: amplitude, offset, start, end, step, cycle count, repetitions and delay.
- A commit writes the staged descriptor into the next free slot of an N_BUF-entry circular queue. The queue drives the channel's packed per-buffer configuration vectors.
- Each buffer-done pulse from the channel retires the active slot, so software can refill slots while playback continues.

Parameters:
- RSZ, 14, buffer address width; pointer fields are RSZ+16 bits.
- N_BUF, 4, number of slots; must be 4 so that slot index matches the channel's 2-bit current buffer index.

Ports:
- dac_clk_i  in  1  DAC clock, single clock domain.
- dac_rst_i  in  1  asynchronous active-high reset.
- sys_we_i  in  1  register write strobe.
- sys_addr_i  in  4  register address.
- sys_wdata_i  in  32  register write data.
- sys_rdata_o  out  32  registered read data.
- buf_done_i  in  1  one-cycle pulse from the channel: active buffer finished.
- set_amp_all_o  out  14*N_BUF  packed amplitude per slot.
- set_dc_all_o  out  14*N_BUF  packed offset per slot.
- set_start_all_o  out  (RSZ+16)*N_BUF  packed start pointer per slot.
- set_end_all_o  out  (RSZ+16)*N_BUF  packed end pointer per slot.
- set_step_all_o  out  (RSZ+16)*N_BUF  packed step per slot.
- set_ncyc_all_o  out  16*N_BUF  packed cycle count per slot.
- set_rnum_all_o  out  16*N_BUF  packed repetition count per slot.
- set_rdly_all_o  out  32*N_BUF  packed repetition delay per slot.
- asg_rst_o  out  1  one-cycle reset request to the channel.
- q_ready_o  out  1  high when level != 0.
- q_level_o  out  3  number of valid slots, 0..N_BUF.

Behaviour:
- Register write map (applies when sys_we_i is high). Staging registers take the low bits of sys_wdata_i:
  - 0: amp [13:0]
  - 1: dc [13:0]
  - 2: start [RSZ+15:0]
  - 3: end [RSZ+15:0]
  - 4: step [RSZ+15:0]
  - 5: ncyc [15:0]
  - 6: rnum [15:0]
  - 7: rdly [31:0]
  - 8: commit (data ignored)
  - 9: control; bit0 = flush, bit1 = clear sticky flags
  - 10–15: writes ignored
- Register read map: addresses 0–7 return the zero-extended staging registers.
- Address 9 reads status: bits [2:0] level, [4:3] wr_ptr, [6:5] rd_ptr, [7] overflow, [8] underrun, [31:9] zero.
- Address 8 and addresses 10–15 read 0.
- sys_rdata_o is registered and valid one cycle after sys_addr_i.
- Reset: all staging registers, slot storage, valid bits, wr_ptr, rd_ptr, level and sticky flags go to 0. asg_rst_o, sys_rdata_o and q_ready_o go to 0. All set_*_all_o vectors go to 0.
- Commit, when level < N_BUF or a retire occurs in the same cycle:
  - Copy staging into slot wr_ptr and set valid[wr_ptr].
  - wr_ptr increments mod N_BUF.
  - Slot outputs and level update on the next cycle.
- Commit when level == N_BUF and no same-cycle retire: dropped; the overflow flag is set (sticky).
- Retire, on buf_done_i with level != 0:
  - Clear valid[rd_ptr]; rd_ptr increments mod N_BUF.
  - The retired slot's outputs hold their last value; the channel no longer selects it.
- Retire on buf_done_i with level == 0: ignored; the underrun flag is set (sticky).
- Simultaneous commit and retire: level is unchanged. When full, wr_ptr == rd_ptr, so the write wins and valid stays 1.
- Underrun stop: if a retire leaves the next slot (rd_ptr+1) invalid, asg_rst_o pulses high one cycle later and the underrun flag is set. This happens unless a commit in the same cycle fills that slot.
- Level: level_next = level + commit_accepted - retire_accepted.
- Flush:
  - Clears valid bits, wr_ptr, rd_ptr and level.
  - Pulses asg_rst_o for exactly one cycle, on the cycle after the write.
  - Staging registers and slot data are retained.
  - A commit in the same cycle as a flush is discarded.
- Clear sticky (control bit1): clears overflow and underrun. If set and clear occur in the same cycle, set wins.
- Reset asserted mid-operation: everything returns to reset values immediately. No asg_rst_o pulse is generated by the reset itself.

Test Plan:
- Write amp=0x1000, end=0x3FFF0000, commit -> next cycle: slot0 fields match, q_level_o=1, q_ready_o=1, status read = 0x009.
- Commit 5 descriptors with no retire -> level=4, 5th dropped, slots 0–3 unchanged, overflow bit7=1.
- Fill 4 slots, pulse buf_done_i and commit in the same cycle -> level stays 4, slot0 holds new data, wr_ptr=1, rd_ptr=1.
- One slot valid, pulse buf_done_i -> level=0, asg_rst_o high exactly one cycle at +1, underrun=1. A second buf_done_i leaves level at 0.
- Fill 3 slots, write control=1 -> level=0, pointers=0, asg_rst_o single pulse. Write control=2 -> flags cleared.
- Assert dac_rst_i asynchronously mid-stream between clock edges -> all outputs 0 immediately, no asg_rst_o pulse after release.
